// File: rtl/demux_tree_node_pkg.sv
`default_nettype none
// ============================================================================
//  demux_tree_node_pkg
//  Shared encodings for the demux tree node: FSM states, side select, entry layout.
//  Revision: 1.0
// ============================================================================
package demux_tree_node_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD_L = 2'd1,
        FWD_R = 2'd2
    } state_e;

    localparam logic SEL_L = 1'b0;
    localparam logic SEL_R = 1'b1;

    // Entry = {data, last, dest}; META_W covers the last and dest bits.
    localparam int META_W    = 2;
    localparam int DEST_BIT  = 0;
    localparam int LAST_BIT  = 1;

    function automatic logic pick_branch(
        input logic l_av,
        input logic r_av,
        input logic prev_sel,
        input logic rr_en
    );
        logic sel;
        sel = SEL_L;
        if (l_av && r_av) begin
            sel = rr_en ? ~prev_sel : SEL_L;
        end else if (r_av) begin
            sel = SEL_R;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_tree_node_skid_fifo2.sv
`default_nettype none
// ============================================================================
//  skid_fifo2
//  Two-entry FIFO with registered occupancy; full/empty decode from the count register.
//  Revision: 1.0
// ============================================================================
module skid_fifo2 #(
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux_tree_node.sv
`default_nettype none
// ============================================================================
//  demux_tree_node
//  One node of a binary packet demux tree: whole packets steered to L or R child.
//  Revision: 1.0
// ============================================================================
module demux_tree_node
    import demux_tree_node_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int RR_ENABLE  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  l_avail,
    output logic [DATA_WIDTH-1:0] l_data,
    output logic                  l_last,
    output logic                  l_valid,
    input  logic                  l_ready,
    input  logic                  r_avail,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_last,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic                  busy,
    output logic                  cur_sel
);

    localparam int ENTRY_W = DATA_WIDTH + META_W;

    state_e                state;
    state_e                next_state;
    logic                  last_sel;
    logic                  run;
    logic                  new_sel;
    logic                  push_dest;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [ENTRY_W-1:0]    head;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;
    logic                  head_dest;
    logic [DATA_WIDTH-1:0] l_data_hold;
    logic                  l_last_hold;
    logic [DATA_WIDTH-1:0] r_data_hold;
    logic                  r_last_hold;

    assign new_sel = pick_branch(l_avail, r_avail, last_sel, RR_ENABLE != 0);

    // run keeps s_ready low while in reset and for the first edge after it.
    assign s_ready = run && !full && ((state != IDLE) || l_avail || r_avail);
    assign push    = s_valid && s_ready;

    always_comb begin
        next_state = state;
        push_dest  = SEL_L;
        case (state)
            IDLE: begin
                push_dest = new_sel;
                if (push && !s_last) begin
                    next_state = (new_sel == SEL_R) ? FWD_R : FWD_L;
                end
            end
            FWD_L: begin
                push_dest = SEL_L;
                if (push && s_last) begin
                    next_state = IDLE;
                end
            end
            FWD_R: begin
                push_dest = SEL_R;
                if (push && s_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_sel <= SEL_R;
            cur_sel  <= SEL_L;
            run      <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= next_state;
            if (push && (state == IDLE)) begin
                last_sel <= new_sel;
                cur_sel  <= new_sel;
            end
        end
    end

    skid_fifo2 #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({s_data, s_last, push_dest}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign head_data = head[ENTRY_W-1:META_W];
    assign head_last = head[LAST_BIT];
    assign head_dest = head[DEST_BIT];

    assign l_valid = !empty && (head_dest == SEL_L);
    assign r_valid = !empty && (head_dest == SEL_R);
    assign pop     = (l_valid && l_ready) || (r_valid && r_ready);

    // The idle side keeps showing the last beat it was offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_data_hold <= '0;
            l_last_hold <= 1'b0;
            r_data_hold <= '0;
            r_last_hold <= 1'b0;
        end else begin
            if (l_valid) begin
                l_data_hold <= head_data;
                l_last_hold <= head_last;
            end
            if (r_valid) begin
                r_data_hold <= head_data;
                r_last_hold <= head_last;
            end
        end
    end

    assign l_data = l_valid ? head_data : l_data_hold;
    assign l_last = l_valid ? head_last : l_last_hold;
    assign r_data = r_valid ? head_data : r_data_hold;
    assign r_last = r_valid ? head_last : r_last_hold;

    assign busy = (state != IDLE) || !empty;

endmodule
`default_nettype wire
